// File: rtl/pwrup_seq_pkg.sv
// Shared definitions for the power-up sequencer: FSM state encoding,
// the default delay-counter width and a width helper for index ports.
package pwrup_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DELAY     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_DONE      = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

    localparam int DEF_CNT_W = 32;

    // Bits needed to index n values, never less than one bit.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous status inputs (lock, power-good).
// Output lags the input by two clock edges; both stages clear on reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back capture stages; meta may go metastable, q should not.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwrup_sequencer.sv
// Power-up sequencer: walks N_STEP output patterns, each after its own delay,
// then waits for a synchronized lock indication. A lock timeout clears the
// outputs and retries the whole sequence up to MAX_RETRY times before failing.
// The current FSM state is exported on fsm_state for observation.
module pwrup_sequencer
    import pwrup_seq_pkg::*;
#(
    parameter int N_OUT       = 4,
    parameter int N_STEP      = 4,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = 200_000_000,
    parameter int MAX_RETRY   = 3,
    parameter bit AUTO_RELOCK = 1'b0
) (
    input  logic                                   REC_CLOCK_C_P,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [N_STEP*CNT_W-1:0]                step_delay,
    input  logic [N_STEP*N_OUT-1:0]                step_mask,
    input  logic                                   lock_in,
    output logic [N_OUT-1:0]                       seq_out,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   fail,
    output logic [width_min1(N_STEP)-1:0]          step_idx,
    output logic [width_min1(MAX_RETRY+1)-1:0]     retry_cnt,
    output seq_state_t                             fsm_state
);

    localparam int               IDX_W       = width_min1(N_STEP);
    localparam int               RTY_W       = width_min1(MAX_RETRY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_STEP - 1);
    localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    seq_state_t       state_q, state_n;
    logic [N_OUT-1:0] seq_q, seq_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [RTY_W-1:0] retry_q, retry_n;
    logic             lock_s;
    logic [CNT_W-1:0] cur_delay;
    logic [N_OUT-1:0] cur_mask;
    logic [CNT_W-1:0] cnt_inc;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk (REC_CLOCK_C_P),
        .rst (rst),
        .d   (lock_in),
        .q   (lock_s)
    );

    assign cur_delay = step_delay[int'(idx_q)*CNT_W +: CNT_W];
    assign cur_mask  = step_mask[int'(idx_q)*N_OUT +: N_OUT];
    // Saturate rather than wrap so a long lock wait cannot alias a small count.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // State and datapath registers; reset wins over everything else.
    always_ff @(posedge REC_CLOCK_C_P) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_n;
            seq_q   <= seq_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            retry_q <= retry_n;
        end
    end

    // Next-state and datapath updates for the sequencing FSM.
    always_comb begin
        state_n = state_q;
        seq_n   = seq_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        retry_n = retry_q;
        case (state_q)
            ST_IDLE: begin
                // Outputs are left as they are when leaving IDLE.
                if (start) begin
                    state_n = ST_DELAY;
                    cnt_n   = '0;
                    idx_n   = '0;
                    retry_n = '0;
                end
            end
            ST_DELAY: begin
                if (cnt_q == cur_delay) begin
                    seq_n = cur_mask;
                    cnt_n = '0;
                    if (idx_q == LAST_IDX) begin
                        state_n = ST_WAIT_LOCK;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is checked first so a lock arriving on the timeout cycle still counts.
                if (lock_s) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    seq_n = '0;
                    cnt_n = '0;
                    if (retry_q < RETRY_LIMIT) begin
                        retry_n = retry_q + RTY_W'(1);
                        idx_n   = '0;
                        state_n = ST_DELAY;
                    end else begin
                        state_n = ST_FAIL;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_n = ST_DELAY;
                    seq_n   = '0;
                    cnt_n   = '0;
                    idx_n   = '0;
                    retry_n = '0;
                end else if (AUTO_RELOCK && !lock_s) begin
                    state_n = ST_DELAY;
                    seq_n   = '0;
                    cnt_n   = '0;
                    idx_n   = '0;
                    retry_n = '0;
                end
            end
            ST_FAIL: begin
                if (start) begin
                    state_n = ST_DELAY;
                    seq_n   = '0;
                    cnt_n   = '0;
                    idx_n   = '0;
                    retry_n = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                seq_n   = '0;
                cnt_n   = '0;
                idx_n   = '0;
                retry_n = '0;
            end
        endcase
    end

    assign seq_out   = seq_q;
    assign busy      = (state_q == ST_DELAY) || (state_q == ST_WAIT_LOCK);
    assign done      = (state_q == ST_DONE);
    assign fail      = (state_q == ST_FAIL);
    assign step_idx  = idx_q;
    assign retry_cnt = retry_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_pwrup_sequencer.sv
// Bench for pwrup_sequencer. Three instances run side by side:
//   a: 3 steps x 4000 cycles, lock driven by the bench (lock, relock-off, held start, reset)
//   b: same configuration with lock never asserted (timeout retries then fail)
//   d: 4 steps with zero delays and short timeout, driven from a per-cycle vector table
// Inputs are driven and outputs sampled on the falling edge.
module tb_pwrup_sequencer;
    import pwrup_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instances a and b ----------------
    logic [95:0] delay_ab = {3{32'd3999}};
    logic [5:0]  mask_ab  = 6'b01_11_01;

    logic       rst_a, start_a, lock_a;
    logic [1:0] seq_a, idx_a, retry_a;
    logic       busy_a, done_a, fail_a;
    seq_state_t state_a;

    logic       rst_b, start_b, lock_b;
    logic [1:0] seq_b, idx_b, retry_b;
    logic       busy_b, done_b, fail_b;
    seq_state_t state_b;

    pwrup_sequencer #(
        .N_OUT(2), .N_STEP(3), .CNT_W(32), .TIMEOUT(100), .MAX_RETRY(2), .AUTO_RELOCK(1'b0)
    ) u_a (
        .REC_CLOCK_C_P(clk), .rst(rst_a), .start(start_a), .step_delay(delay_ab),
        .step_mask(mask_ab), .lock_in(lock_a), .seq_out(seq_a), .busy(busy_a),
        .done(done_a), .fail(fail_a), .step_idx(idx_a), .retry_cnt(retry_a),
        .fsm_state(state_a)
    );

    pwrup_sequencer #(
        .N_OUT(2), .N_STEP(3), .CNT_W(32), .TIMEOUT(100), .MAX_RETRY(2), .AUTO_RELOCK(1'b0)
    ) u_b (
        .REC_CLOCK_C_P(clk), .rst(rst_b), .start(start_b), .step_delay(delay_ab),
        .step_mask(mask_ab), .lock_in(lock_b), .seq_out(seq_b), .busy(busy_b),
        .done(done_b), .fail(fail_b), .step_idx(idx_b), .retry_cnt(retry_b),
        .fsm_state(state_b)
    );

    // ---------------- instance d ----------------
    logic [31:0] delay_d = 32'h0;
    logic [15:0] mask_d  = 16'hF731;

    logic       rst_d, start_d, lock_d;
    logic [3:0] seq_d;
    logic [1:0] idx_d;
    logic [0:0] retry_d;
    logic       busy_d, done_d, fail_d;
    seq_state_t state_d;

    pwrup_sequencer #(
        .N_OUT(4), .N_STEP(4), .CNT_W(8), .TIMEOUT(3), .MAX_RETRY(1), .AUTO_RELOCK(1'b1)
    ) u_d (
        .REC_CLOCK_C_P(clk), .rst(rst_d), .start(start_d), .step_delay(delay_d),
        .step_mask(mask_d), .lock_in(lock_d), .seq_out(seq_d), .busy(busy_d),
        .done(done_d), .fail(fail_d), .step_idx(idx_d), .retry_cnt(retry_d),
        .fsm_state(state_d)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the falling edge after rising edge number 'target' (relative count).
    task automatic goto(inout int now, input int target);
        repeat (target - now) @(negedge clk);
        now = target;
    endtask

    // done and fail must never be high together on any instance.
    always @(negedge clk) begin
        if (!rst_a && !rst_b && !rst_d) begin
            check("done_fail_excl", {29'd0, done_a & fail_a, done_b & fail_b, done_d & fail_d}, 32'd0);
        end
    end

    // ---------------- vector table for instance d ----------------
    typedef struct {
        logic       rst;
        logic       start;
        logic       lock;
        logic [3:0] seq;
        logic       busy;
        logic       done;
        logic       fail;
        logic [1:0] idx;
        logic       retry;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic s, input logic l, input logic [3:0] q,
                           input logic b, input logic dn, input logic f,
                           input logic [1:0] i, input logic rt);
        vec_t v;
        v.rst = r; v.start = s; v.lock = l; v.seq = q; v.busy = b;
        v.done = dn; v.fail = f; v.idx = i; v.retry = rt;
        vecs.push_back(v);
    endtask

    task automatic run_d();
        //       rst start lock  seq  busy done fail idx retry
        add_vec(0, 1, 0, 4'h0, 1, 0, 0, 2'd0, 0); // r0  start
        add_vec(0, 0, 0, 4'h1, 1, 0, 0, 2'd1, 0); // r1  masks on 4 consecutive edges
        add_vec(0, 0, 0, 4'h3, 1, 0, 0, 2'd2, 0);
        add_vec(0, 0, 0, 4'h7, 1, 0, 0, 2'd3, 0);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 0); // r4  into WAIT_LOCK
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 0);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 0);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 0);
        add_vec(0, 0, 0, 4'h0, 1, 0, 0, 2'd0, 1); // r8  timeout -> retry 1
        add_vec(0, 0, 0, 4'h1, 1, 0, 0, 2'd1, 1);
        add_vec(0, 0, 0, 4'h3, 1, 0, 0, 2'd2, 1);
        add_vec(0, 0, 0, 4'h7, 1, 0, 0, 2'd3, 1);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 1); // r12 WAIT_LOCK, cnt 0
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 1);
        add_vec(0, 0, 1, 4'hF, 1, 0, 0, 2'd3, 1); // r14 lock rises
        add_vec(0, 0, 1, 4'hF, 1, 0, 0, 2'd3, 1);
        add_vec(0, 0, 1, 4'hF, 0, 1, 0, 2'd3, 1); // r16 lock and timeout together -> DONE
        add_vec(0, 0, 1, 4'hF, 0, 1, 0, 2'd3, 1);
        add_vec(0, 0, 0, 4'hF, 0, 1, 0, 2'd3, 1); // r18 lock drops
        add_vec(0, 0, 0, 4'hF, 0, 1, 0, 2'd3, 1);
        add_vec(0, 0, 0, 4'h0, 1, 0, 0, 2'd0, 0); // r20 auto relock restart
        add_vec(0, 0, 0, 4'h1, 1, 0, 0, 2'd1, 0);
        add_vec(0, 0, 0, 4'h3, 1, 0, 0, 2'd2, 0);
        add_vec(1, 1, 0, 4'h0, 0, 0, 0, 2'd0, 0); // r23 reset beats start
        add_vec(0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 0);
        add_vec(0, 1, 0, 4'h0, 1, 0, 0, 2'd0, 0); // r25 start, lock never comes
        add_vec(0, 0, 0, 4'h1, 1, 0, 0, 2'd1, 0);
        add_vec(0, 0, 0, 4'h3, 1, 0, 0, 2'd2, 0);
        add_vec(0, 0, 0, 4'h7, 1, 0, 0, 2'd3, 0);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 0);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 0);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 0);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 0);
        add_vec(0, 0, 0, 4'h0, 1, 0, 0, 2'd0, 1); // r33 retry 1
        add_vec(0, 0, 0, 4'h1, 1, 0, 0, 2'd1, 1);
        add_vec(0, 0, 0, 4'h3, 1, 0, 0, 2'd2, 1);
        add_vec(0, 0, 0, 4'h7, 1, 0, 0, 2'd3, 1);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 1);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 1);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 1);
        add_vec(0, 0, 0, 4'hF, 1, 0, 0, 2'd3, 1);
        add_vec(0, 0, 0, 4'h0, 0, 0, 1, 2'd3, 1); // r41 retries exhausted -> FAIL
        add_vec(0, 0, 0, 4'h0, 0, 0, 1, 2'd3, 1);
        add_vec(0, 1, 0, 4'h0, 1, 0, 0, 2'd0, 0); // r43 start from FAIL
        add_vec(0, 1, 0, 4'h1, 1, 0, 0, 2'd1, 0); // r44 held start ignored while busy
        add_vec(0, 0, 0, 4'h3, 1, 0, 0, 2'd2, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_d   = vecs[i].rst;
            start_d = vecs[i].start;
            lock_d  = vecs[i].lock;
            @(negedge clk);
            check($sformatf("d_vec[%0d] {seq,busy,done,fail,idx,retry}", i),
                  {22'd0, seq_d, busy_d, done_d, fail_d, idx_d, retry_d},
                  {22'd0, vecs[i].seq, vecs[i].busy, vecs[i].done, vecs[i].fail,
                   vecs[i].idx, vecs[i].retry});
        end
        rst_d   = 1'b0;
        start_d = 1'b0;
        lock_d  = 1'b0;
    endtask

    // ---------------- instance a: lock, held start, mid-sequence reset ----------------
    task automatic run_a();
        int t;
        start_a = 1'b1;
        @(negedge clk);
        t = 0;
        start_a = 1'b0;
        check("a_start_busy", {31'd0, busy_a}, 32'd1);
        check("a_start_seq", {30'd0, seq_a}, 32'd0);
        goto(t, 3999);  check("a_seq@3999", {30'd0, seq_a}, 32'd0);
        goto(t, 4000);  check("a_seq@4000", {30'd0, seq_a}, 32'd1);
                        check("a_idx@4000", {30'd0, idx_a}, 32'd1);
        goto(t, 7999);  check("a_seq@7999", {30'd0, seq_a}, 32'd1);
        goto(t, 8000);  check("a_seq@8000", {30'd0, seq_a}, 32'd3);
        goto(t, 11999); check("a_seq@11999", {30'd0, seq_a}, 32'd3);
        goto(t, 12000); check("a_seq@12000", {30'd0, seq_a}, 32'd1);
                        check("a_busy@12000", {31'd0, busy_a}, 32'd1);
        lock_a = 1'b1;
        goto(t, 12002); check("a_done@12002", {30'd0, done_a, busy_a}, 32'b01);
        goto(t, 12003); check("a_done@12003", {28'd0, done_a, busy_a, seq_a}, 32'b1001);
                        check("a_fail@12003", {31'd0, fail_a}, 32'd0);
        // lock lost with relock disabled: stays DONE
        lock_a = 1'b0;
        goto(t, 12013); check("a_norelock", {28'd0, done_a, busy_a, seq_a}, 32'b1001);

        // start held through a whole sequence
        start_a = 1'b1;
        @(negedge clk);
        t = 0;
        check("a_held_restart", {28'd0, done_a, busy_a, seq_a}, 32'b0100);
        goto(t, 4000);  check("a_held_seq@4000", {30'd0, seq_a}, 32'd1);
        goto(t, 8000);  check("a_held_seq@8000", {30'd0, seq_a}, 32'd3);
        goto(t, 12000); check("a_held_seq@12000", {30'd0, seq_a}, 32'd1);
        lock_a = 1'b1;
        goto(t, 12003); check("a_held_done", {31'd0, done_a}, 32'd1);
        goto(t, 12004); check("a_held_redo", {26'd0, done_a, busy_a, seq_a, idx_a}, 32'b010000);
        start_a = 1'b0;

        // reset pulsed 6000 edges into the sequence, with start asserted too
        t = 0;
        goto(t, 5999);  check("a_pre_rst", {27'd0, busy_a, seq_a, idx_a}, 32'b10101);
        rst_a   = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        check("a_rst_mid", {24'd0, seq_a, busy_a, done_a, fail_a, idx_a, retry_a}, 32'd0);
        rst_a   = 1'b0;
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        check("a_idle_after_rst", {27'd0, seq_a, busy_a, done_a, fail_a}, 32'd0);

        // full sequence again with lock already stable
        start_a = 1'b1;
        @(negedge clk);
        t = 0;
        start_a = 1'b0;
        goto(t, 3999);  check("a2_seq@3999", {30'd0, seq_a}, 32'd0);
        goto(t, 4000);  check("a2_seq@4000", {30'd0, seq_a}, 32'd1);
        goto(t, 8000);  check("a2_seq@8000", {30'd0, seq_a}, 32'd3);
        goto(t, 12000); check("a2_seq@12000", {29'd0, done_a, seq_a}, 32'b001);
        goto(t, 12001); check("a2_done@12001", {28'd0, done_a, busy_a, seq_a}, 32'b1001);
    endtask

    // ---------------- instance b: lock timeout, retries, fail ----------------
    task automatic run_b();
        int t;
        start_b = 1'b1;
        @(negedge clk);
        t = 0;
        start_b = 1'b0;
        goto(t, 4000);  check("b_seq@4000", {30'd0, seq_b}, 32'd1);
        goto(t, 12000); check("b_seq@12000", {27'd0, busy_b, seq_b, idx_b}, 32'b10110);
        goto(t, 12100); check("b_pre_to", {27'd0, seq_b, retry_b, busy_b}, 32'b01001);
        goto(t, 12101); check("b_retry1", {25'd0, seq_b, retry_b, busy_b, idx_b}, 32'b0001100);
        goto(t, 16101); check("b_r1_seq@4000", {30'd0, seq_b}, 32'd1);
        goto(t, 24201); check("b_pre_to2", {27'd0, seq_b, retry_b, busy_b}, 32'b01011);
        goto(t, 24202); check("b_retry2", {27'd0, seq_b, retry_b, busy_b}, 32'b00101);
        goto(t, 36302); check("b_pre_fail", {28'd0, busy_b, fail_b, seq_b}, 32'b1001);
        goto(t, 36303); check("b_fail", {25'd0, fail_b, done_b, busy_b, seq_b, retry_b}, 32'b1000010);
        goto(t, 36313); check("b_fail_hold", {28'd0, fail_b, busy_b, seq_b}, 32'b1000);
    endtask

    // ---------------- main ----------------
    initial begin
        rst_a = 1'b1; start_a = 1'b0; lock_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; lock_b = 1'b0;
        rst_d = 1'b1; start_d = 1'b0; lock_d = 1'b0;
        repeat (3) @(negedge clk);
        check("a_reset", {24'd0, seq_a, busy_a, done_a, fail_a, idx_a, retry_a}, 32'd0);
        check("b_reset", {24'd0, seq_b, busy_b, done_b, fail_b, idx_b, retry_b}, 32'd0);
        check("d_reset", {22'd0, seq_d, busy_d, done_d, fail_d, idx_d, retry_d}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_d = 1'b0;
        fork
            run_a();
            run_b();
            run_d();
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwrup_sequencer.md
PWRUP_SEQUENCER -- requirements
Module: pwrup_sequencer

Interface
REQ-001 SHALL have parameter N_OUT, default 4, number of sequenced output bits.
REQ-002 SHALL have parameter N_STEP, default 4, number of sequence steps (>=1).
REQ-003 SHALL have parameter CNT_W, default 32, width of delay counter.
REQ-004 SHALL have parameter TIMEOUT, default 200_000_000, lock-wait limit in cycles.
REQ-005 SHALL have parameter MAX_RETRY, default 3, full-sequence retries before failure.
REQ-006 SHALL have parameter AUTO_RELOCK, default 0, 1 = restart sequence on lock loss in DONE.
REQ-007 SHALL have ports: REC_CLOCK_C_P  in  1  clock; rst  in  1  reset, synchronous, active-high; clock REC_CLOCK_C_P.
REQ-008 SHALL have start  in  1  begin/restart request, level sampled per edge.
REQ-009 SHALL have step_delay  in  N_STEP*CNT_W  per-step delay, step k at bits [k*CNT_W +: CNT_W], static while busy.
REQ-010 SHALL have step_mask  in  N_STEP*N_OUT  per-step output value, step k at [k*N_OUT +: N_OUT].
REQ-011 SHALL have lock_in  in  1  asynchronous lock indication (e.g. PLL lock).
REQ-012 SHALL have seq_out  out  N_OUT; busy, done, fail  out  1 each; step_idx  out  $clog2(N_STEP) (min 1); retry_cnt  out  $clog2(MAX_RETRY+1).

Function
REQ-013 SHALL implement states IDLE, DELAY, WAIT_LOCK, DONE, FAIL.
REQ-014 SHALL pass lock_in through a two-flop synchronizer; lock_s denotes its output (2-cycle latency).
REQ-015 IDLE: start=1 -> DELAY, step_idx=0, cnt=0, retry_cnt=0, busy=1, done=0, fail=0; seq_out unchanged.
REQ-016 DELAY: cnt increments each cycle; when cnt==step_delay[step_idx]: seq_out<=step_mask[step_idx], cnt<=0, step_idx++ or, at step N_STEP-1, -> WAIT_LOCK.
REQ-017 Timing: start sampled at edge T -> step k mask registered at edge T + sum_{j<=k}(delay_j+1); delay 0 gives 1 cycle per step.
REQ-018 WAIT_LOCK: cnt increments; lock_s=1 -> DONE (lock has priority over a simultaneous timeout).
REQ-019 WAIT_LOCK: cnt==TIMEOUT and lock_s=0 -> if retry_cnt<MAX_RETRY: retry_cnt++, seq_out<=0, step_idx=0, cnt=0, -> DELAY; else seq_out<=0 -> FAIL.
REQ-020 DONE: done=1, busy=0, seq_out held; lock_s falling with AUTO_RELOCK=1 -> seq_out<=0, retry_cnt=0, -> DELAY at step 0; AUTO_RELOCK=0 -> remain DONE.
REQ-021 FAIL: fail=1, busy=0, seq_out=0 held.
REQ-022 start in DONE or FAIL SHALL behave as in IDLE and additionally clear seq_out to 0 on the same edge.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 cnt SHALL never wrap; delay compare is exact equality at CNT_W bits.
REQ-025 done and fail SHALL never be 1 simultaneously; busy=1 exactly in DELAY and WAIT_LOCK.

Reset
REQ-026 rst=1 at any edge, including mid-sequence, SHALL force IDLE, seq_out=0, busy=0, done=0, fail=0, step_idx=0, retry_cnt=0, cnt=0, synchronizer flops=0.
REQ-027 rst SHALL dominate start on the same edge.

Structure
REQ-028 State encoding and default CNT_W SHALL live in shared package pwrup_seq_pkg.
REQ-029 The lock synchronizer SHALL be a sub-module sync_2ff, reusable for other async status inputs.
REQ-030 All logic SHALL be in the REC_CLOCK_C_P domain; no latches, no blocking assignments in sequential logic.

Verification
REQ-031 N_STEP=3, N_OUT=2, delays {3999,3999,3999}, masks {01,11,01}, lock_in=1, start at T -> seq_out=01 @T+4000, 11 @T+8000, 01 @T+12000, done=1 @T+12003.
REQ-032 Same config, lock_in=0, TIMEOUT=100, MAX_RETRY=2 -> seq_out cleared and sequence repeated twice (retry_cnt 1,2), then fail=1, seq_out=0, busy=0.
REQ-033 All delays 0, N_STEP=4 -> masks appear on four consecutive edges T+1..T+4.
REQ-034 rst pulsed at T+6000 of REQ-031 sequence -> next edge all outputs at reset values; start later -> full sequence timing per REQ-031.
REQ-035 AUTO_RELOCK=1, in DONE drop lock_in -> 2-3 cycles later seq_out=0, busy=1, sequence restarts at step 0; AUTO_RELOCK=0 -> done stays 1.
REQ-036 start held high throughout sequence -> no restart while busy; in DONE the held start restarts on the first DONE edge.
